// File: rtl/time_entry_register_pkg.sv
// Shared types and limits for the keypad time-entry register.
// BCD digit type, entry FSM state encoding and the range limits used by validation.
`timescale 1ns/1ps
package time_entry_register_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_LOCKED   = 2'd3
   } entry_state_t;

   localparam bcd_t BCD_MAX      = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;

   function automatic logic bcd_is_digit(input bcd_t code);
      return code <= BCD_MAX;
   endfunction

endpackage

// File: rtl/time_entry_register_key_debouncer.sv
// Key-press qualifier: a code must be valid and unchanged for DEBOUNCE_CYCLES samples,
// then it is reported once with a 1-cycle key_accept_o and ignored until the key is released.
//
//  state       | meaning
//  ------------+---------------------------------------------------------------
//  ST_IDLE     | no key being qualified; waiting for key-valid with entry enabled
//  ST_DEBOUNCE | candidate code captured; counting down the remaining stable samples
//  ST_HELD     | code already reported; waiting for one released sample
//  ST_LOCKED   | entry handed to the timer; keypad ignored until clear_i
`timescale 1ns/1ps
module time_entry_register_key_debouncer
   import time_entry_register_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic         clock,
   input  logic         clearn,
   input  logic         clear_i,
   input  logic         lock_i,
   input  logic         enablen_i,
   input  logic         loadn_i,
   input  bcd_t         bcd_i,
   output logic         key_accept_o,
   output bcd_t         key_code_o,
   output entry_state_t state_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   entry_state_t     state_q, state_d;
   bcd_t             code_q, code_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             key_ok;

   assign key_ok = loadn_i && !enablen_i;

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         remain_q <= remain_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      code_d       = code_q;
      remain_d     = remain_q;
      key_accept_o = 1'b0;

      if (clear_i) begin
         state_d  = ST_IDLE;
         remain_d = '0;
      end else if (lock_i) begin
         state_d  = ST_LOCKED;
         remain_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (key_ok) begin
                  code_d = bcd_i;
                  if (DEBOUNCE_CYCLES <= 1) begin
                     key_accept_o = 1'b1;
                     state_d      = ST_HELD;
                  end else begin
                     remain_d = CNT_W'(DEBOUNCE_CYCLES - 1);
                     state_d  = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               // Down-counter holds the stable samples still required; terminal count is 1.
               if (key_ok && (bcd_i == code_q)) begin
                  if (remain_q == CNT_W'(1)) begin
                     key_accept_o = 1'b1;
                     remain_d     = '0;
                     state_d      = ST_HELD;
                  end else begin
                     remain_d = remain_q - CNT_W'(1);
                  end
               end else begin
                  remain_d = '0;
                  state_d  = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (!loadn_i) state_d = ST_IDLE;
            end
            ST_LOCKED: begin
               state_d = ST_LOCKED;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Only a 1-cycle debounce accepts straight from IDLE, before the code is registered.
   assign key_code_o = (state_q == ST_IDLE) ? bcd_i : code_q;
   assign state_o    = state_q;

endmodule

// File: rtl/time_entry_register.sv
// Microwave-style MM:SS entry register: debounced digits shift in from the right,
// and a start press validates the entry and hands it to the countdown timer.
`timescale 1ns/1ps
module time_entry_register
   import time_entry_register_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_DIGITS      = 4
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic       enablen,
   input  logic [3:0] bcd_in,
   input  logic       loadn,
   input  logic       clear_entry,
   input  logic       start,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic [2:0] digit_count,
   output logic       time_load,
   output logic       time_err
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

   bcd_t         min_tens_q,  min_tens_d;
   bcd_t         min_units_q, min_units_d;
   bcd_t         sec_tens_q,  sec_tens_d;
   bcd_t         sec_units_q, sec_units_d;
   logic [2:0]   count_q,     count_d;
   logic         start_q;
   logic         time_load_q, time_load_d;
   logic         time_err_q,  time_err_d;

   logic         key_accept;
   bcd_t         key_code;
   entry_state_t key_state;
   logic         locked;
   logic         start_act;
   logic         entry_ok;
   logic         lock_req;
   logic         shift_en;

   time_entry_register_key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debouncer (
      .clock        (clock),
      .clearn       (clearn),
      .clear_i      (clear_entry),
      .lock_i       (lock_req),
      .enablen_i    (enablen),
      .loadn_i      (loadn),
      .bcd_i        (bcd_in),
      .key_accept_o (key_accept),
      .key_code_o   (key_code),
      .state_o      (key_state)
   );

   assign locked    = (key_state == ST_LOCKED);
   assign start_act = start && !start_q && !locked && !clear_entry;
   assign entry_ok  = (sec_tens_q <= SEC_TENS_MAX) &&
                      ({min_tens_q, min_units_q, sec_tens_q, sec_units_q} != '0);
   assign lock_req  = start_act && entry_ok;
   // A start acting this cycle validates the pre-shift digits, so the digit is dropped.
   assign shift_en  = key_accept && !clear_entry && !start_act &&
                      bcd_is_digit(key_code) && (count_q < MAX_CNT);

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         min_tens_q  <= '0;
         min_units_q <= '0;
         sec_tens_q  <= '0;
         sec_units_q <= '0;
         count_q     <= '0;
         start_q     <= 1'b0;
         time_load_q <= 1'b0;
         time_err_q  <= 1'b0;
      end else begin
         min_tens_q  <= min_tens_d;
         min_units_q <= min_units_d;
         sec_tens_q  <= sec_tens_d;
         sec_units_q <= sec_units_d;
         count_q     <= count_d;
         start_q     <= start;
         time_load_q <= time_load_d;
         time_err_q  <= time_err_d;
      end
   end

   always_comb begin
      min_tens_d  = min_tens_q;
      min_units_d = min_units_q;
      sec_tens_d  = sec_tens_q;
      sec_units_d = sec_units_q;
      count_d     = count_q;
      time_load_d = 1'b0;
      time_err_d  = 1'b0;

      if (clear_entry) begin
         min_tens_d  = '0;
         min_units_d = '0;
         sec_tens_d  = '0;
         sec_units_d = '0;
         count_d     = '0;
      end else begin
         time_load_d = lock_req;
         time_err_d  = start_act && !entry_ok;
         if (shift_en) begin
            min_tens_d  = min_units_q;
            min_units_d = sec_tens_q;
            sec_tens_d  = sec_units_q;
            sec_units_d = key_code;
            count_d     = count_q + 3'd1;
         end
      end
   end

   assign min_tens    = min_tens_q;
   assign min_units   = min_units_q;
   assign sec_tens    = sec_tens_q;
   assign sec_units   = sec_units_q;
   assign digit_count = count_q;
   assign time_load   = time_load_q;
   assign time_err    = time_err_q;

endmodule

// File: tb/tb_time_entry_register.sv
// Self-checking bench for time_entry_register: a press-level reference model compared every
// cycle, plus hand-computed digit/pulse expectations after each directed scenario.
`timescale 1ns/1ps
module tb_time_entry_register;

   logic       clock = 1'b0;
   logic       clearn = 1'b1;
   logic       enablen = 1'b0;
   logic [3:0] bcd_in = 4'd0;
   logic       loadn = 1'b0;
   logic       clear_entry = 1'b0;
   logic       start = 1'b0;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic [2:0] digit_count;
   logic       time_load, time_err;

   int checks = 0;
   int failures = 0;
   int n_load = 0;
   int n_err = 0;

   time_entry_register dut (
      .clock       (clock),
      .clearn      (clearn),
      .enablen     (enablen),
      .bcd_in      (bcd_in),
      .loadn       (loadn),
      .clear_entry (clear_entry),
      .start       (start),
      .min_tens    (min_tens),
      .min_units   (min_units),
      .sec_tens    (sec_tens),
      .sec_units   (sec_units),
      .digit_count (digit_count),
      .time_load   (time_load),
      .time_err    (time_err)
   );

   always #5 clock = ~clock;

   // Reference model: digits as a small array, a press is the length of the current
   // run of identical valid samples; one acceptance per press, re-armed by a release.
   int  m_dig [4] = '{0, 0, 0, 0};
   int  m_cnt = 0;
   bit  m_locked = 0;
   bit  m_holding = 0;
   int  m_run = 0;
   int  m_code = 0;
   bit  m_start_prev = 0;
   bit  m_load = 0;
   bit  m_err = 0;

   always @(posedge clock or negedge clearn) begin
      bit rise, s_act, fire, nz;
      if (!clearn) begin
         m_dig = '{0, 0, 0, 0};
         m_cnt = 0; m_locked = 0; m_holding = 0; m_run = 0; m_code = 0;
         m_start_prev = 0; m_load = 0; m_err = 0;
      end else begin
         rise = start && !m_start_prev;
         m_start_prev = start;
         m_load = 0;
         m_err = 0;
         if (clear_entry) begin
            m_dig = '{0, 0, 0, 0};
            m_cnt = 0; m_locked = 0; m_holding = 0; m_run = 0;
         end else begin
            s_act = rise && !m_locked;
            fire = 0;
            if (!m_locked) begin
               if (m_holding) begin
                  if (!loadn) m_holding = 0;
               end else if (m_run == 0) begin
                  if (loadn && !enablen) begin
                     m_run = 1;
                     m_code = int'(bcd_in);
                  end
               end else if (loadn && !enablen && int'(bcd_in) == m_code) begin
                  m_run++;
                  if (m_run == 4) begin
                     fire = 1; m_holding = 1; m_run = 0;
                  end
               end else begin
                  m_run = 0;
               end
            end
            if (s_act) begin
               nz = (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) != 0;
               if (m_dig[2] <= 5 && nz) begin
                  m_load = 1; m_locked = 1; m_holding = 0; m_run = 0;
               end else begin
                  m_err = 1;
               end
            end
            if (fire && !s_act && m_code <= 9 && m_cnt < 4) begin
               m_dig[0] = m_dig[1];
               m_dig[1] = m_dig[2];
               m_dig[2] = m_dig[3];
               m_dig[3] = m_code;
               m_cnt++;
            end
         end
      end
   end

   always @(negedge clock) begin
      logic [18:0] got, exp;
      got = {min_tens, min_units, sec_tens, sec_units, digit_count, time_load, time_err};
      exp = {m_dig[0][3:0], m_dig[1][3:0], m_dig[2][3:0], m_dig[3][3:0], m_cnt[2:0], m_load, m_err};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL model_cmp t=%0t got=%0d%0d:%0d%0d cnt=%0d ld=%0b err=%0b expected=%0d%0d:%0d%0d cnt=%0d ld=%0b err=%0b",
                  $time, min_tens, min_units, sec_tens, sec_units, digit_count, time_load, time_err,
                  m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_cnt, m_load, m_err);
      end
      if (time_load === 1'b1) n_load++;
      if (time_err === 1'b1) n_err++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold);
      bcd_in = code;
      loadn = 1'b1;
      step(hold);
      loadn = 1'b0;
      step(2);
   endtask

   task automatic do_clear();
      clear_entry = 1'b1;
      step(1);
      clear_entry = 1'b0;
      step(1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(3);
      start = 1'b0;
      step(2);
   endtask

   task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_digits(input string name, input int mt, input int mu, input int st,
                               input int su, input int cnt);
      checks++;
      if (min_tens !== 4'(mt) || min_units !== 4'(mu) || sec_tens !== 4'(st) ||
          sec_units !== 4'(su) || digit_count !== 3'(cnt)) begin
         failures++;
         $display("FAIL %s got=%0d%0d:%0d%0d cnt=%0d expected=%0d%0d:%0d%0d cnt=%0d", name,
                  min_tens, min_units, sec_tens, sec_units, digit_count, mt, mu, st, su, cnt);
      end
   endtask

   initial begin
      #1 clearn = 1'b0;
      step(3);
      check_digits("reset_digits", 0, 0, 0, 0, 0);
      check_val("reset_pulses", {14'd0, time_load, time_err}, 16'd0);
      clearn = 1'b1;
      step(2);

      press(4'd1, 6); press(4'd3, 6); press(4'd0, 6);
      check_digits("clean_130", 0, 1, 3, 0, 3);

      do_clear();
      check_digits("clear_entry", 0, 0, 0, 0, 0);
      bcd_in = 4'd7;
      for (int i = 0; i < 10; i++) begin
         loadn = ((i / 2) % 2) == 0;
         step(1);
      end
      loadn = 1'b1;
      step(6);
      loadn = 1'b0;
      step(2);
      check_digits("bounce_7_once", 0, 0, 0, 7, 1);

      do_clear();
      press(4'd5, 50);
      check_digits("long_hold_5", 0, 0, 0, 5, 1);
      press(4'd5, 6);
      check_digits("repress_5", 0, 0, 5, 5, 2);

      do_clear();
      for (int d = 1; d <= 5; d++) press(4'(d), 6);
      check_digits("overflow_drop5", 1, 2, 3, 4, 4);

      do_clear();
      enablen = 1'b1;
      press(4'd8, 6);
      enablen = 1'b0;
      check_digits("enablen_locked_out", 0, 0, 0, 0, 0);
      press(4'd12, 6);
      check_digits("code_gt9_dropped", 0, 0, 0, 0, 0);
      bcd_in = 4'd2; loadn = 1'b1;
      step(2);
      bcd_in = 4'd3;
      step(6);
      loadn = 1'b0;
      step(2);
      check_digits("glitch_code_change", 0, 0, 0, 3, 1);

      do_clear();
      press(4'd0, 6); press(4'd9, 6); press(4'd9, 6);
      n_load = 0; n_err = 0;
      pulse_start();
      check_val("err_sec_tens_pulses", 16'(n_err), 16'd1);
      check_val("err_no_load", 16'(n_load), 16'd0);
      check_digits("err_digits_kept", 0, 0, 9, 9, 3);

      do_clear();
      press(4'd0, 6); press(4'd0, 6);
      n_load = 0; n_err = 0;
      pulse_start();
      check_val("err_all_zero", 16'(n_err), 16'd1);

      do_clear();
      press(4'd1, 6);
      n_load = 0; n_err = 0;
      start = 1'b1; clear_entry = 1'b1;
      step(1);
      clear_entry = 1'b0;
      step(2);
      start = 1'b0;
      step(2);
      check_val("clear_beats_start", 16'(n_load + n_err), 16'd0);
      check_digits("clear_beats_start_digits", 0, 0, 0, 0, 0);

      press(4'd1, 6); press(4'd3, 6); press(4'd0, 6);
      n_load = 0; n_err = 0;
      pulse_start();
      check_val("load_pulse_once", 16'(n_load), 16'd1);
      press(4'd8, 6);
      check_digits("locked_ignores_8", 0, 1, 3, 0, 3);
      pulse_start();
      check_val("locked_ignores_start", 16'(n_load + n_err), 16'd1);
      do_clear();
      press(4'd8, 6);
      check_digits("unlocked_after_clear", 0, 0, 0, 8, 1);

      do_clear();
      press(4'd2, 6);
      n_load = 0; n_err = 0;
      bcd_in = 4'd4; loadn = 1'b1;
      step(3);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      loadn = 1'b0;
      step(2);
      check_val("start_with_accept_load", 16'(n_load), 16'd1);
      check_digits("start_with_accept_digits", 0, 0, 0, 2, 1);

      do_clear();
      press(4'd4, 6); press(4'd2, 6);
      check_digits("pre_reset_42", 0, 0, 4, 2, 2);
      bcd_in = 4'd6; loadn = 1'b1;
      step(2);
      clearn = 1'b0;
      #1;
      check_digits("async_reset_digits", 0, 0, 0, 0, 0);
      check_val("async_reset_pulses", {14'd0, time_load, time_err}, 16'd0);
      step(2);
      clearn = 1'b1;
      step(8);
      loadn = 1'b0;
      step(2);
      check_digits("held_through_reset", 0, 0, 0, 6, 1);

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
